// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/writeback
// and decoding op/funct into every datapath enable and mux select.
module mc_control_fsm #(
  parameter logic [3:0] FETCH_ENC    = 4'd0,
  parameter bit         TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH   = FETCH_ENC,
    DECODE  = FETCH_ENC + 4'd1,
    MEMADR  = FETCH_ENC + 4'd2,
    MEMRD   = FETCH_ENC + 4'd3,
    MEMWB   = FETCH_ENC + 4'd4,
    MEMWR   = FETCH_ENC + 4'd5,
    EXECUTE = FETCH_ENC + 4'd6,
    ALUWB   = FETCH_ENC + 4'd7,
    BRANCH  = FETCH_ENC + 4'd8,
    IEXEC   = FETCH_ENC + 4'd9,
    IWB     = FETCH_ENC + 4'd10,
    JUMP    = FETCH_ENC + 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic       pcwrite, branch, bne;
  logic [2:0] rtype_alu, imm_alu;
  logic       imm_zext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    rtype_alu = ALU_ADD;
    case (funct)
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_alu = ALU_ADD;
    endcase
  end

  // Immediate-op decode is shared by IEXEC and IWB so the ALU setup holds through writeback.
  always_comb begin
    imm_alu  = ALU_ADD;
    imm_zext = 1'b0;
    case (op)
      OP_ANDI: begin imm_alu = ALU_AND; imm_zext = 1'b1; end
      OP_ORI:  begin imm_alu = ALU_OR;  imm_zext = 1'b1; end
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d    = FETCH;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    illegal    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;

    case (state_q)
      FETCH: begin
        irwrite    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        pcwrite    = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW:                      state_d = MEMADR;
          OP_RTYPE:                          state_d = EXECUTE;
          OP_BEQ, OP_BNE:                    state_d = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEXEC;
          OP_J:                              state_d = JUMP;
          default: begin
            state_d = FETCH;
            illegal = TRAP_ILLEGAL;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        state_d    = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = (op == OP_BEQ);
        bne        = (op == OP_BNE);
      end
      IEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = imm_alu;
        zeroext    = imm_zext;
        state_d    = IWB;
      end
      IWB: begin
        regwrite   = 1'b1;
        alucontrol = imm_alu;
        zeroext    = imm_zext;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    pcen = pcwrite | (branch & zero) | (bne & ~zero);
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: each instruction is expanded into its expected
// per-cycle control vectors from the instruction class, then compared cycle by cycle.
module tb_mc_control_fsm;

  logic       clk = 1'b1;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       zeroext, illegal;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  mc_control_fsm #(.FETCH_ENC(4'd0), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .pcen(pcen),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // pcm: 0 never, 1 always, 2 when zero, 3 when not zero
  typedef struct {
    logic [3:0] st;
    logic       mw, ir, rw;
    int         pcm;
    logic       io, m2r, rdst, asa;
    logic [1:0] asb;
    logic       zx;
    logic [1:0] psrc;
    logic [2:0] ac;
    logic       ill;
  } exp_t;

  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t phase(input logic [3:0] st);
    exp_t e;
    e = '{st: st, mw: 1'b0, ir: 1'b0, rw: 1'b0, pcm: 0, io: 1'b0, m2r: 1'b0,
          rdst: 1'b0, asa: 1'b0, asb: 2'b00, zx: 1'b0, psrc: 2'b00, ac: 3'b000, ill: 1'b0};
    return e;
  endfunction

  function automatic bit supported(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                     6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
  endfunction

  function automatic logic [2:0] rtype_op(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic build(input logic [5:0] o, input logic [5:0] f);
    exp_t e;
    q.delete();
    e = phase(4'd0); e.ir = 1'b1; e.pcm = 1; e.asb = 2'b01; e.ac = 3'b010; q.push_back(e);
    e = phase(4'd1); e.asb = 2'b11; e.ac = 3'b010; e.ill = !supported(o); q.push_back(e);
    if (o == 6'b100011 || o == 6'b101011) begin
      e = phase(4'd2); e.asa = 1'b1; e.asb = 2'b10; e.ac = 3'b010; q.push_back(e);
      if (o == 6'b100011) begin
        e = phase(4'd3); e.io = 1'b1; q.push_back(e);
        e = phase(4'd4); e.m2r = 1'b1; e.rw = 1'b1; q.push_back(e);
      end else begin
        e = phase(4'd5); e.io = 1'b1; e.mw = 1'b1; q.push_back(e);
      end
    end else if (o == 6'b000000) begin
      e = phase(4'd6); e.asa = 1'b1; e.ac = rtype_op(f); q.push_back(e);
      e = phase(4'd7); e.rdst = 1'b1; e.rw = 1'b1; q.push_back(e);
    end else if (o == 6'b000100 || o == 6'b000101) begin
      e = phase(4'd8); e.asa = 1'b1; e.ac = 3'b110; e.psrc = 2'b01;
      e.pcm = (o == 6'b000100) ? 2 : 3; q.push_back(e);
    end else if (o inside {6'b001000, 6'b001100, 6'b001101, 6'b001010}) begin
      logic [2:0] ac;
      logic       zx;
      case (o)
        6'b001100: begin ac = 3'b000; zx = 1'b1; end
        6'b001101: begin ac = 3'b001; zx = 1'b1; end
        6'b001010: begin ac = 3'b111; zx = 1'b0; end
        default:   begin ac = 3'b010; zx = 1'b0; end
      endcase
      e = phase(4'd9); e.asa = 1'b1; e.asb = 2'b10; e.ac = ac; e.zx = zx; q.push_back(e);
      e = phase(4'd10); e.rw = 1'b1; e.ac = ac; e.zx = zx; q.push_back(e);
    end else if (o == 6'b000010) begin
      e = phase(4'd11); e.psrc = 2'b10; e.pcm = 1; q.push_back(e);
    end
  endtask

  task automatic check_cycle(input exp_t e, input int cyc, input logic [5:0] o);
    logic        exp_pcen;
    logic [16:0] got_v, exp_v;
    exp_pcen = (e.pcm == 1) || (e.pcm == 2 && zero) || (e.pcm == 3 && !zero);
    got_v = {memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca,
             alusrcb, zeroext, pcsrc, alucontrol, illegal};
    exp_v = {e.mw, e.ir, e.rw, exp_pcen, e.io, e.m2r, e.rdst, e.asa,
             e.asb, e.zx, e.psrc, e.ac, e.ill};
    check($sformatf("state op=%b cyc=%0d", o, cyc + 1), 32'(state_o), 32'(e.st));
    check($sformatf("outputs op=%b cyc=%0d zero=%b", o, cyc + 1, zero), 32'(got_v), 32'(exp_v));
    check($sformatf("mw_rw_excl op=%b cyc=%0d", o, cyc + 1), 32'(memwrite & regwrite), 32'd0);
  endtask

  // zsel: 0/1 hold zero fixed, 2 randomize each cycle; abort_at: cycle index after which
  // reset is asserted between edges (-1 for none)
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel,
                           input int abort_at);
    build(o, f);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin op = o; funct = f; end
      zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
      #1;
      check_cycle(q[i], i, o);
      if (i == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check("abort state", 32'(state_o), 32'd0);
        check("abort irwrite", 32'(irwrite), 32'd1);
        check("abort pcen", 32'(pcen), 32'd1);
        check("abort regwrite", 32'(regwrite), 32'd0);
        @(posedge clk);
        #1;
        check("abort held state", 32'(state_o), 32'd0);
        reset = 1'b0;
        return;
      end
    end
  endtask

  logic [5:0] ops_tbl [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                               6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
  logic [5:0] fn_tbl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    #1 reset = 1'b0;
    run_instr(6'b100011, 6'b000000, 2, -1);
    run_instr(6'b101011, 6'b000000, 2, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b000101, 6'b000000, 1, -1);
    run_instr(6'b000101, 6'b000000, 0, -1);
    run_instr(6'b000000, 6'b100010, 2, -1);
    run_instr(6'b000000, 6'b111111, 2, -1);
    run_instr(6'b001101, 6'b000000, 2, -1);
    run_instr(6'b111111, 6'b000000, 2, -1);
    run_instr(6'b100011, 6'b000000, 2, 3);
    run_instr(6'b000010, 6'b000000, 2, -1);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops_tbl[$urandom_range(0, 9)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tbl[$urandom_range(0, 4)];
      run_instr(o, f, 2, ($urandom_range(0, 19) == 0) ? 1 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
